// File: rtl/double_eq_if.sv
// double_eq_if: operand pair and equality result bundle for double_eq
interface double_eq_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        z;
  modport master (output a, output b, input z);
  modport slave  (input a, input b, output z);
endinterface

// File: rtl/double_eq.sv
// double_eq: registered IEEE-754 binary64 quiet equality, one result per clock
module double_eq (
  input  logic      clk,
  input  logic      rst_n,
  double_eq_if.slave bus
);
  logic a_nan, b_nan, a_zero, b_zero, z_d, z_q;
  assign a_nan  = (&bus.a[62:52]) && (|bus.a[51:0]);
  assign b_nan  = (&bus.b[62:52]) && (|bus.b[51:0]);
  assign a_zero = ~|bus.a[62:0];
  assign b_zero = ~|bus.b[62:0];
  // NaN poisons even bit-identical pairs; signed zeros are the only non-bitwise match
  always_comb z_d = (a_nan || b_nan) ? 1'b0 : (a_zero && b_zero) ? 1'b1 : (bus.a == bus.b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) z_q <= 1'b0;
    else        z_q <= z_d;
  assign bus.z = z_q;
endmodule

// File: tb/tb_double_eq.sv
// tb_double_eq: scoreboard bench for double_eq with directed and random pairs
module tb_double_eq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  double_eq_if bus ();
  double_eq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { bit e; int id; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int next_id = 0;

  task automatic chk(input string n, input int id, input logic act, input logic e);
    checks++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s #%0d: z=%0b expected %0b (t=%0t)", n, id, act, e, $time);
    end
  endtask

  initial forever begin
    exp_t t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      chk("stream", t.id, bus.z, t.e);
    end
  end

  task automatic drive(input logic [63:0] x, input logic [63:0] y, input bit e);
    exp_t t;
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    t.e = e;
    t.id = next_id++;
    exp_q.push_back(t);
  endtask

  function automatic bit ref_eq(input logic [63:0] x, input logic [63:0] y);
    return $bitstoreal(x) == $bitstoreal(y);
  endfunction

  logic [63:0] specials [6] = '{64'h7FF8000000000000, 64'h7FF0000000000001, 64'h0000000000000000,
                                64'h8000000000000000, 64'h7FF0000000000000, 64'hFFF0000000000000};

  initial begin
    logic [63:0] x, y;
    int r;
    bus.a = 64'h3FF0000000000000;
    bus.b = 64'h3FF0000000000000;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", -1, bus.z, 1'b0);
    end
    drive(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1);
    rst_n = 1'b1;
    drive(64'h0000000000000000, 64'h8000000000000000, 1'b1);
    drive(64'h0000000000000000, 64'h0000000000000001, 1'b0);
    drive(64'h7FF8000000000000, 64'h7FF8000000000000, 1'b0);
    drive(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0);
    drive(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1);
    drive(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0);
    drive(64'h4000000000000000, 64'h4000000000000001, 1'b0);
    drive(64'h8000000000000000, 64'h8000000000000000, 1'b1);
    drive(64'h0000000000000001, 64'h0000000000000001, 1'b1);
    drive(64'h8000000000000001, 64'h0000000000000001, 1'b0);
    drive(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    drive(64'hC00921FB54442D18, 64'hC00921FB54442D18, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(64'h3FF8000000000000, 64'h3FF8000000000000, 1'b1);
      drive(64'h3FF8000000000000, 64'hBFF8000000000000, 1'b0);
    end
    drive(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", -1, bus.z, 1'b0);
    drive(64'h0000000000000000, 64'h8000000000000000, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(99);
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (r < 10) y = x;
      else if (r < 15) begin
        x = specials[$urandom_range(5)];
        y = specials[$urandom_range(5)];
      end
      drive(x, y, ref_eq(x, y));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/double_eq.md
DOUBLE_EQ -- requirements
Module: double_eq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  64  operand A, IEEE-754 binary64 (bit 63 sign, bits 62:52 exponent, bits 51:0 fraction).
REQ-005 b  input  64  operand B, same format as a.
REQ-006 z  output  1  registered comparison result: 1 = a equals b under IEEE-754 quiet equality, 0 otherwise.

Function
REQ-007 Operand classification SHALL be combinational per operand:
- NaN = exponent all-ones and fraction nonzero.
- Zero = exponent zero and fraction zero.
- Infinity = exponent all-ones and fraction zero.
- Subnormal = exponent zero and fraction nonzero.
- Otherwise normal.
REQ-008 If either operand is NaN (quiet or signalling, either sign), the result SHALL be 0, including when a and b are bit-identical.
REQ-009 If both operands are zero, the result SHALL be 1 regardless of sign bits (+0 == -0).
REQ-010 In all other cases, the result SHALL be 1 exactly when all 64 bits of a equal all 64 bits of b, else 0.
REQ-011 Consequences of REQ-010:
- +inf == +inf; +inf != -inf.
- Subnormals compare bitwise, with no flush-to-zero.
- Zero never equals a subnormal.
REQ-012 z SHALL be registered with latency exactly 1 clock: the value on a/b sampled at rising edge N SHALL appear on z immediately after edge N and hold until edge N+1.
REQ-013 The block SHALL accept a new operand pair on every rising edge (throughput 1/clock) with no handshake, enable or valid signals.
REQ-014 The block SHALL raise no exception flags and have no other outputs; signalling NaN SHALL be treated identically to quiet NaN.
REQ-015 The datapath SHALL contain no state other than the z register.

Reset
REQ-016 While rst_n = 0, z SHALL be 0, asserted asynchronously without waiting for a clock edge.
REQ-017 On the first rising clk edge with rst_n = 1, z SHALL take the comparison of the a/b values present at that edge.
REQ-018 Reset deasserted mid-stream SHALL need no flush cycles; there is no warm-up.

Verification
REQ-019 Reset: rst_n = 0 with a = b = 0x3FF0000000000000 and clk running -> z = 0 throughout; first edge after rst_n = 1 -> z = 1.
REQ-020 Zeros: a = 0x0000000000000000, b = 0x8000000000000000 -> z = 1; a = 0x0000000000000000, b = 0x0000000000000001 -> z = 0.
REQ-021 NaN: a = b = 0x7FF8000000000000 -> z = 0; a = 0x7FF0000000000001 (sNaN), b = 0x3FF0000000000000 -> z = 0.
REQ-022 Infinities/normals: a = b = 0x7FF0000000000000 -> z = 1; a = 0x7FF0000000000000, b = 0xFFF0000000000000 -> z = 0; a = 0x4000000000000000, b = 0x4000000000000001 -> z = 0.
REQ-023 Pipelining: apply alternating equal/unequal pairs on consecutive edges -> z matches each pair's result exactly one cycle later, with no bubbles.
REQ-024 Random: at least 10,000 random pairs, 10% forced bit-identical and 5% NaN/zero/inf special values, checked against a reference IEEE-754 equality model with 1-cycle alignment -> zero mismatches.
